// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - branch/jump resolution stage with 2-bit bimodal predictor
//
// Resolves conditional branches, JAL and JALR one cycle after acceptance,
// trains a direct-mapped table of 2-bit saturating counters and keeps
// performance counters.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 pipeline kill: drops the pending result, blocks input
//   in_valid / in_ready   input handshake
//   in_pc, in_imm,        instruction operands
//   in_rs1, in_rs2
//   in_funct3             branch condition (BEQ/BNE/BLT/BGE/BLTU/BGEU)
//   in_op                 00 branch, 01 JAL, 10 JALR, 11 reserved
//   in_pred_taken         frontend prediction for this instruction
//   out_valid / out_ready output handshake
//   out_taken, out_target, out_link, out_mispredict, out_redirect_pc
//                         registered resolution result
//   lookup_pc / lookup_taken  combinational predictor read for fetch
//   stat_resolved, stat_mispredict  wrapping performance counters
module branch_resolve_unit #(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [2:0]      in_funct3,
  input  logic [1:0]      in_op,
  input  logic            in_pred_taken,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_taken,
  output logic [XLEN-1:0] out_target,
  output logic [XLEN-1:0] out_link,
  output logic            out_mispredict,
  output logic [XLEN-1:0] out_redirect_pc,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            lookup_taken,
  output logic [31:0]     stat_resolved,
  output logic [31:0]     stat_mispredict
);

  localparam int IDXW = $clog2(BHT_DEPTH);

  localparam logic [1:0] OP_BRANCH = 2'b00;
  localparam logic [1:0] OP_JAL    = 2'b01;
  localparam logic [1:0] OP_JALR   = 2'b10;

  // Registered state
  logic            out_valid_q, out_valid_d;
  logic            out_taken_q, out_taken_d;
  logic            out_mispredict_q, out_mispredict_d;
  logic [XLEN-1:0] out_target_q, out_target_d;
  logic [XLEN-1:0] out_link_q, out_link_d;
  logic [XLEN-1:0] out_redirect_q, out_redirect_d;
  logic [31:0]     stat_resolved_q, stat_resolved_d;
  logic [31:0]     stat_mispredict_q, stat_mispredict_d;
  logic [1:0]      bht_q [BHT_DEPTH];
  logic [1:0]      bht_d [BHT_DEPTH];

  // Combinational resolution of the incoming instruction
  logic            accept;
  logic            handshake;
  logic            cond_taken;
  logic            res_taken;
  logic            res_mispredict;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] res_target;
  logic [IDXW-1:0] upd_idx;
  logic [IDXW-1:0] rd_idx;

  // Only the index bits of lookup_pc take part in the read.
  logic            unused_lookup_bits;
  assign unused_lookup_bits = ^{lookup_pc[XLEN-1:IDXW+2], lookup_pc[1:0]};

  assign in_ready  = !flush && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  // A result leaving under flush is discarded, so it is not a handshake.
  assign handshake = out_valid_q && out_ready && !flush;
  assign upd_idx   = in_pc[IDXW+1:2];
  assign rd_idx    = lookup_pc[IDXW+1:2];

  // Reads the registered table, so a same-cycle update is not yet visible.
  assign lookup_taken = bht_q[rd_idx][1];

  always_comb begin
    cond_taken = 1'b0;
    case (in_funct3)
      3'b000:  cond_taken = (in_rs1 == in_rs2);
      3'b001:  cond_taken = (in_rs1 != in_rs2);
      3'b100:  cond_taken = ($signed(in_rs1) < $signed(in_rs2));
      3'b101:  cond_taken = ($signed(in_rs1) >= $signed(in_rs2));
      3'b110:  cond_taken = (in_rs1 < in_rs2);
      3'b111:  cond_taken = (in_rs1 >= in_rs2);
      default: cond_taken = 1'b0;
    endcase
  end

  always_comb begin
    pc_plus4       = in_pc + XLEN'(4);
    jalr_sum       = in_rs1 + in_imm;
    res_taken      = 1'b0;
    res_mispredict = 1'b0;
    res_target     = in_pc + in_imm;
    case (in_op)
      OP_BRANCH: begin
        res_taken      = cond_taken;
        res_mispredict = (cond_taken != in_pred_taken);
      end
      OP_JAL: begin
        res_taken      = 1'b1;
        res_mispredict = 1'b1;
      end
      OP_JALR: begin
        res_taken      = 1'b1;
        res_mispredict = 1'b1;
        res_target     = {jalr_sum[XLEN-1:1], 1'b0};
      end
      default: begin
        res_taken      = 1'b0;
        res_mispredict = 1'b0;
      end
    endcase
  end

  // Output register, statistics and predictor next-state
  always_comb begin
    out_valid_d       = out_valid_q;
    out_taken_d       = out_taken_q;
    out_mispredict_d  = out_mispredict_q;
    out_target_d      = out_target_q;
    out_link_d        = out_link_q;
    out_redirect_d    = out_redirect_q;
    stat_resolved_d   = stat_resolved_q;
    stat_mispredict_d = stat_mispredict_q;
    bht_d             = bht_q;

    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      out_taken_d      = res_taken;
      out_mispredict_d = res_mispredict;
      out_target_d     = res_target;
      out_link_d       = pc_plus4;
      out_redirect_d   = res_taken ? res_target : pc_plus4;
    end

    if (handshake) begin
      stat_resolved_d = stat_resolved_q + 32'd1;
      if (out_mispredict_q) begin
        stat_mispredict_d = stat_mispredict_q + 32'd1;
      end
    end

    if (accept && (in_op == OP_BRANCH)) begin
      if (cond_taken) begin
        if (bht_q[upd_idx] != 2'b11) begin
          bht_d[upd_idx] = bht_q[upd_idx] + 2'b01;
        end
      end else begin
        if (bht_q[upd_idx] != 2'b00) begin
          bht_d[upd_idx] = bht_q[upd_idx] - 2'b01;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q       <= 1'b0;
      out_taken_q       <= 1'b0;
      out_mispredict_q  <= 1'b0;
      out_target_q      <= '0;
      out_link_q        <= '0;
      out_redirect_q    <= '0;
      stat_resolved_q   <= '0;
      stat_mispredict_q <= '0;
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht_q[i] <= 2'b01;
      end
    end else begin
      out_valid_q       <= out_valid_d;
      out_taken_q       <= out_taken_d;
      out_mispredict_q  <= out_mispredict_d;
      out_target_q      <= out_target_d;
      out_link_q        <= out_link_d;
      out_redirect_q    <= out_redirect_d;
      stat_resolved_q   <= stat_resolved_d;
      stat_mispredict_q <= stat_mispredict_d;
      bht_q             <= bht_d;
    end
  end

  assign out_valid       = out_valid_q;
  assign out_taken       = out_taken_q;
  assign out_mispredict  = out_mispredict_q;
  assign out_target      = out_target_q;
  assign out_link        = out_link_q;
  assign out_redirect_pc = out_redirect_q;
  assign stat_resolved   = stat_resolved_q;
  assign stat_mispredict = stat_mispredict_q;

endmodule
